// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, fixed latency.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_WIDTH-1:0] count;
  logic [2:0]           op;
  logic [W-1:0]         a_org;
  logic [W-1:0]         b_mag;
  logic [W-1:0]         res_q;
  logic [2*W-1:0]       acc;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 div_zero;
  logic                 div_ovf;

  logic           a_signed, b_signed;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag_in, b_mag_in;
  logic           accept, last;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic [2*W-1:0] acc_nx;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   res_nx;

  always_comb begin
    a_signed = (MulDivOp == 3'b001) || (MulDivOp == 3'b010) ||
               (MulDivOp == 3'b100) || (MulDivOp == 3'b110);
    b_signed = (MulDivOp == 3'b001) || (MulDivOp == 3'b100) ||
               (MulDivOp == 3'b110);
    a_neg    = a_signed & SrcA[W-1];
    b_neg    = b_signed & SrcB[W-1];
    a_mag_in = a_neg ? -SrcA : SrcA;
    b_mag_in = b_neg ? -SrcB : SrcB;
    accept   = (state == S_IDLE) && Start && !Flush;
    last     = (count == LAST);
  end

  // acc holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
    rem_sh  = acc[2*W-1:W-1];
    diff    = rem_sh - {1'b0, b_mag};
    acc_nx  = {mul_sum, acc[W-1:1]};
    if (op[2]) begin
      if (diff[W])
        acc_nx = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      else
        acc_nx = {diff[W-1:0], acc[W-2:0], 1'b1};
    end
  end

  always_comb begin
    prod   = neg_res ? -acc_nx : acc_nx;
    quo    = neg_res ? -acc_nx[W-1:0] : acc_nx[W-1:0];
    rem    = neg_rem ? -acc_nx[2*W-1:W] : acc_nx[2*W-1:W];
    res_nx = rem;
    if (op == 3'b000)      res_nx = prod[W-1:0];
    else if (!op[2])       res_nx = prod[2*W-1:W];
    else if (div_zero)     res_nx = op[1] ? a_org : '1;
    else if (div_ovf)      res_nx = op[1] ? '0 : a_org;
    else if (!op[1])       res_nx = quo;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (Start) state_nx = S_CALC;
      S_CALC:  if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (Flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      op       <= '0;
      a_org    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      res_q    <= '0;
    end else if (accept) begin
      count    <= '0;
      op       <= MulDivOp;
      a_org    <= SrcA;
      b_mag    <= b_mag_in;
      acc      <= {{W{1'b0}}, a_mag_in};
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= MulDivOp[2] && (SrcB == '0);
      div_ovf  <= MulDivOp[2] && !MulDivOp[0] &&
                  (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    end else if (state == S_CALC && !Flush) begin
      acc <= acc_nx;
      if (last) res_q <= res_nx;
      else      count <= count + 1'b1;
    end
  end

  assign Busy   = (state != S_IDLE);
  assign Done   = (state == S_DONE);
  assign Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        Flush;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int tests = 0;
  int fails = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Flush(Flush),
    .MulDivOp(MulDivOp), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int     sa, sb;
    longint p;
    logic [63:0] u;
    sa = a;
    sb = b;
    ref_model = '0;
    case (op)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; ref_model = u[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); ref_model = p[63:32]; end
      3'd2: begin
        p = longint'(sa) * longint'({32'b0, b});
        ref_model = p[63:32];
      end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; ref_model = u[63:32]; end
      3'd4: begin
        if (b == 0) ref_model = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_model = a;
        else ref_model = sa / sb;
      end
      3'd5: ref_model = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) ref_model = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_model = 0;
        else ref_model = sa % sb;
      end
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op; lat = sample index (1 = first after acceptance) of Done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r,
                        output int lat, output int busy_n);
    @(negedge clk);
    Start = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0;
    MulDivOp = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 0;
    busy_n = 0;
    for (int k = 1; k <= 100; k++) begin
      if (Busy) busy_n++;
      if (Done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    r = Result;
    if (lat == 0) begin
      tests++; fails++;
      $display("FAIL timeout: no Done within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];
  logic [31:0] r;
  logic [31:0] a, b;
  logic [2:0]  op;
  int lat, busy_n, dones;

  initial begin
    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0;
    MulDivOp = '0; SrcA = '0; SrcB = '0;
    #12;
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    check("reset_result", Result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    vecs = '{
      '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
      '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
      '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
      '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
      '{3'd5, 32'd100,      32'd7,        32'd14},
      '{3'd7, 32'd100,      32'd7,        32'd2},
      '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF},
      '{3'd6, 32'd5,        32'd0,        32'd5},
      '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, busy_n);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 32'd33);
      check($sformatf("vec%0d_busy", i), busy_n, 32'd33);
    end
    check("idle_after_done", {31'b0, Busy}, 32'd0);

    // Flush mid-CALC: Result keeps the previous value, no Done
    run_op(3'd0, 32'd3, 32'd5, r, lat, busy_n);
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1; Start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); Flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", {31'b0, Busy}, 32'd0);
    check("flush_done", {31'b0, Done}, 32'd0);
    Flush = 1'b0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) dones++; end
    check("flush_no_done", dones, 32'd0);
    check("flush_result_kept", Result, 32'd15);

    // Start held through CALC starts nothing extra
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'd7; SrcA = 32'd1000; SrcB = 32'd7;
    dones = 0;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (Done) dones++; end
    Start = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (Done) dones++; end
    check("held_start_dones", dones, 32'd1);
    check("held_start_result", Result, 32'd6);

    // Back-to-back: Start during DONE ignored, accepted next in IDLE
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'd0; SrcA = 32'd6; SrcB = 32'd7;
    @(posedge clk); #1; Start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (Done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    check("b2b_first_latency", lat, 32'd33);
    check("b2b_first_result", Result, 32'd42);
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'd5; SrcA = 32'd81; SrcB = 32'd9;
    @(posedge clk); #1;
    check("b2b_start_in_done_ignored", {31'b0, Busy}, 32'd0);
    @(posedge clk); #1;
    check("b2b_second_accepted", {31'b0, Busy}, 32'd1);
    Start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (Done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    check("b2b_second_latency", lat, 32'd33);
    check("b2b_second_result", Result, 32'd9);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'd1; SrcA = 32'h12345678; SrcB = 32'h9abcdef0;
    @(posedge clk); #1; Start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_result", Result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) dones++; end
    check("rst_no_done", dones, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, r, lat, busy_n);
    check("post_rst_result", r, 32'd12);
    check("post_rst_latency", lat, 32'd33);

    // Random ops with occasional edge-case operands
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(op, a, b, r, lat, busy_n);
      check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b),
            r, ref_model(op, a, b));
      check($sformatf("rand%0d_latency", i), lat, 32'd33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
